datapath_regs: RTL and testbench

Register bank and bus-driving stage directly upstream and downstream of the ALU. Holds the processor's architectural registers. Drives the ALU's A operand from the accumulator and its B operand through a source mux. Captures the ALU result and zero flag at the clock edge under control-unit enables. Also provides the memory address and instruction outputs consumed by the control unit and data memory.

---
 rtl/datapath_regs.sv | 119 +++++++++++
 tb/tb_datapath_regs.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/datapath_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : datapath_regs                                                 |
// | Purpose  : architectural register bank feeding and capturing the ALU.    |
// |            Optional macro ZFLAG_REG_EN makes z_flag a held register.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module datapath_regs #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] PC_RESET = 16'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] C_bus,
    input  logic             Z,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [7:0]       write_en,
    input  logic [2:0]       inc_en,
    input  logic             load_mem,
    input  logic [2:0]       b_sel,
    output logic [WIDTH-1:0] A_bus,
    output logic [WIDTH-1:0] B_bus,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] ir,
    output logic             z_flag
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_ac;
    logic [WIDTH-1:0] r_r1;
    logic [WIDTH-1:0] r_r2;
    logic [WIDTH-1:0] r_tr;
    logic [WIDTH-1:0] r_dr;
    logic [WIDTH-1:0] r_ar;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ir;

    // Plain write-only registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ac <= '0;
            r_r2 <= '0;
            r_tr <= '0;
            r_ir <= '0;
        end else begin
            if (write_en[0]) r_ac <= C_bus;
            if (write_en[2]) r_r2 <= C_bus;
            if (write_en[3]) r_tr <= C_bus;
            if (write_en[7]) r_ir <= C_bus;
        end
    end

    // Memory read data takes precedence over the ALU write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dr <= '0;
        end else if (load_mem) begin
            r_dr <= mem_data;
        end else if (write_en[4]) begin
            r_dr <= C_bus;
        end
    end

    // Write-back wins over increment; increments wrap silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ar <= '0;
            r_pc <= PC_RESET;
            r_r1 <= '0;
        end else begin
            if (write_en[5])    r_ar <= C_bus;
            else if (inc_en[0]) r_ar <= r_ar + c_one;

            if (write_en[6])    r_pc <= C_bus;
            else if (inc_en[1]) r_pc <= r_pc + c_one;

            if (write_en[1])    r_r1 <= C_bus;
            else if (inc_en[2]) r_r1 <= r_r1 + c_one;
        end
    end

    always_comb begin
        B_bus = '0;
        case (b_sel)
            3'd0:    B_bus = r_dr;
            3'd1:    B_bus = r_r1;
            3'd2:    B_bus = r_r2;
            3'd3:    B_bus = r_tr;
            3'd4:    B_bus = r_pc;
            3'd5:    B_bus = r_ar;
            3'd6:    B_bus = r_ir;
            default: B_bus = '0;
        endcase
    end

    assign A_bus = r_ac;
    assign addr  = r_ar;
    assign ir    = r_ir;

`ifdef ZFLAG_REG_EN
    logic r_z;

    // Zero flag tracks the value most recently written into AC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_z <= 1'b0;
        end else if (write_en[0]) begin
            r_z <= Z;
        end
    end

    assign z_flag = r_z;
`else
    assign z_flag = Z;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_datapath_regs                                              |
// | Purpose  : self-checking bench for datapath_regs with a register model.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_datapath_regs;

    localparam int          W   = 16;
    localparam logic [15:0] PCR = 16'h0100;
    // Register order in the model follows the write_en bit order.
    localparam int AC = 0, R1 = 1, R2 = 2, TR = 3, DR = 4, AR = 5, PC = 6, IR = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  C_bus, mem_data;
    logic          Z, load_mem;
    logic [7:0]    write_en;
    logic [2:0]    inc_en, b_sel;
    logic [W-1:0]  A_bus, B_bus, addr, ir;
    logic          z_flag;

    logic [W-1:0]  m [8];
    logic          mz;
    logic          chk_on = 1'b0;
    int            n_pass = 0;
    int            n_total = 0;

    datapath_regs #(.WIDTH(W), .PC_RESET(PCR)) dut (
        .clk(clk), .rst(rst), .C_bus(C_bus), .Z(Z), .mem_data(mem_data),
        .write_en(write_en), .inc_en(inc_en), .load_mem(load_mem), .b_sel(b_sel),
        .A_bus(A_bus), .B_bus(B_bus), .addr(addr), .ir(ir), .z_flag(z_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m[i] = '0;
        m[PC] = PCR;
        mz = 1'b0;
    endtask

    function automatic logic [W-1:0] exp_b(input logic [2:0] bs);
        case (bs)
            3'd0: return m[DR];
            3'd1: return m[R1];
            3'd2: return m[R2];
            3'd3: return m[TR];
            3'd4: return m[PC];
            3'd5: return m[AR];
            3'd6: return m[IR];
            default: return '0;
        endcase
    endfunction

    function automatic logic exp_z();
`ifdef ZFLAG_REG_EN
        return mz;
`else
        return Z;
`endif
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_A_bus", A_bus, m[AC]);
            check("cyc_B_bus", B_bus, exp_b(b_sel));
            check("cyc_addr", addr, m[AR]);
            check("cyc_ir", ir, m[IR]);
            check("cyc_z_flag", {15'd0, z_flag}, {15'd0, exp_z()});
        end
    end

    task automatic drive(input logic [7:0] we, input logic [2:0] inc, input logic lm,
                         input logic [W-1:0] md, input logic [W-1:0] c, input logic z,
                         input logic [2:0] bs);
        write_en = we; inc_en = inc; load_mem = lm;
        mem_data = md; C_bus = c; Z = z; b_sel = bs;
    endtask

    // Advance one clock edge and apply the register-transfer rules to the model.
    task automatic edge_step();
        logic [W-1:0] n [8];
        @(posedge clk);
        if (!rst) begin
            n = m;
            for (int i = 0; i < 8; i++) if (write_en[i]) n[i] = C_bus;
            if (!write_en[AR] && inc_en[0]) n[AR] = m[AR] + 16'd1;
            if (!write_en[PC] && inc_en[1]) n[PC] = m[PC] + 16'd1;
            if (!write_en[R1] && inc_en[2]) n[R1] = m[R1] + 16'd1;
            if (load_mem) n[DR] = mem_data;
            if (write_en[AC]) mz = Z;
            m = n;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(8'h00, 3'd0, 1'b0, '0, '0, 1'b0, 3'd0);
        model_reset();
        #2 chk_on = 1'b1;

        // Reset values on every B_bus source.
        for (int s = 0; s < 8; s++) begin
            b_sel = 3'(s);
            #1 check("rst_B_bus", B_bus, (s == 4) ? PCR : 16'h0000);
        end
        check("rst_A_bus", A_bus, 16'h0000);
        check("rst_addr", addr, 16'h0000);
        check("rst_z_flag", {15'd0, z_flag}, 16'h0000);
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;

        // Write-back to AC and R1 together.
        drive(8'b0000_0011, 3'd0, 1'b0, '0, 16'h1234, 1'b0, 3'd0); edge_step();
        b_sel = 3'd1; #1;
        check("wb_A_bus", A_bus, 16'h1234);
        check("wb_B_r1", B_bus, 16'h1234);
        b_sel = 3'd2; #1 check("wb_B_r2_untouched", B_bus, 16'h0000);
        check("wb_model_ac", m[AC], 16'h1234);

        // PC increment wrap, then write beats increment.
        drive(8'b0100_0000, 3'd0, 1'b0, '0, 16'hFFFF, 1'b0, 3'd4); edge_step();
        drive(8'h00, 3'b010, 1'b0, '0, 16'h7777, 1'b0, 3'd4); edge_step();
        check("pc_wrap", B_bus, 16'h0000);
        check("pc_wrap_model", m[PC], 16'h0000);
        drive(8'b0100_0000, 3'b010, 1'b0, '0, 16'h0040, 1'b0, 3'd4); edge_step();
        check("pc_write_over_inc", B_bus, 16'h0040);

        // DR: memory load beats write-back.
        drive(8'b0001_0000, 3'd0, 1'b1, 16'hBEEF, 16'h0001, 1'b0, 3'd0); edge_step();
        check("dr_load_mem", B_bus, 16'hBEEF);
        check("dr_addr_unaffected", addr, 16'h0000);

        // Read-modify-write of R1 uses the old value.
        drive(8'b0000_0010, 3'd0, 1'b0, '0, 16'd5, 1'b0, 3'd1); edge_step();
        drive(8'b0000_0010, 3'd0, 1'b0, '0, 16'd10, 1'b0, 3'd1);
        #1 check("rmw_before", B_bus, 16'd5);
        edge_step();
        check("rmw_after", B_bus, 16'd10);
        b_sel = 3'd7; #1 check("bsel_zero", B_bus, 16'h0000);

        // Zero flag behaviour.
        drive(8'b0000_0001, 3'd0, 1'b0, '0, 16'h0000, 1'b1, 3'd7);
`ifdef ZFLAG_REG_EN
        edge_step();
        drive(8'h00, 3'd0, 1'b0, '0, 16'h0000, 1'b0, 3'd7);
        #1 check("z_captured", {15'd0, z_flag}, 16'h0001);
        edge_step();
        check("z_held", {15'd0, z_flag}, 16'h0001);
`else
        #1 check("z_pass_hi", {15'd0, z_flag}, 16'h0001);
        Z = 1'b0;
        #1 check("z_pass_lo", {15'd0, z_flag}, 16'h0000);
        edge_step();
`endif

        // Asynchronous reset mid-cycle with every register loaded.
        drive(8'hFF, 3'd0, 1'b0, '0, 16'hA5A5, 1'b1, 3'd4); edge_step();
        drive(8'h00, 3'd0, 1'b0, '0, 16'h0000, 1'b0, 3'd4);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("arst_A_bus", A_bus, 16'h0000);
        check("arst_B_pc", B_bus, PCR);
        check("arst_ir", ir, 16'h0000);
        check("arst_addr", addr, 16'h0000);
        @(posedge clk) #1 rst = 1'b0;
        edge_step();
        check("arst_hold_pc", B_bus, PCR);
        check("arst_hold_A", A_bus, 16'h0000);

        // Randomized traffic, with occasional mid-cycle resets.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1 check("rand_arst_A", A_bus, 16'h0000);
                @(posedge clk) #1 rst = 1'b0;
            end else begin
                drive(8'($urandom_range(0, 255) & $urandom_range(0, 255)),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                      16'($urandom), ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
                edge_step();
            end
        end

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
